// File: rtl/des128_pkg.sv
// Shared types and constants for the 128-bit DES key scheduler.
// Optional feature macro used by this slice: DES128_DECRYPT_EN.
package des128_pkg;

  localparam int HALF_W = 56;
  localparam int ROUNDS = 16;
  localparam int RND_W  = $clog2(ROUNDS);

  typedef enum logic {
    IDLE,
    EMIT
  } state_t;

  // Encodings chosen so the rotator can decode the amount directly.
  typedef enum logic [1:0] {
    ROT_1  = 2'd1,
    ROT_2  = 2'd2,
    ROT_28 = 2'd3
  } rot_amt_t;

  // Index 0 holds the shift applied to form round 1.
  localparam rot_amt_t SHIFT_SCHED [ROUNDS] = '{
    ROT_1, ROT_1, ROT_2, ROT_2, ROT_2, ROT_2, ROT_2, ROT_2,
    ROT_1, ROT_2, ROT_2, ROT_2, ROT_2, ROT_2, ROT_2, ROT_1
  };

endpackage

// File: rtl/des128_key_scheduler_if.sv
// Key-in and round-state-out handshake bundle for des128_key_scheduler.
interface des128_key_scheduler_if;
  import des128_pkg::*;

  logic              key_valid;
  logic              key_ready;
  logic [HALF_W-1:0] C0_in;
  logic [HALF_W-1:0] D0_in;
  logic              mode_dec;
  logic              rk_valid;
  logic              rk_ready;
  logic [HALF_W-1:0] rk_C;
  logic [HALF_W-1:0] rk_D;
  logic [RND_W-1:0]  rk_round;
  logic              rk_last;

  modport master (
    output key_valid, C0_in, D0_in, mode_dec, rk_ready,
    input  key_ready, rk_valid, rk_C, rk_D, rk_round, rk_last
  );

  modport slave (
    input  key_valid, C0_in, D0_in, mode_dec, rk_ready,
    output key_ready, rk_valid, rk_C, rk_D, rk_round, rk_last
  );

endinterface

// File: rtl/des128_half_rotator.sv
// Rotates one 56-bit key half by 1, 2 or 28 positions.
// Right rotation exists only when DES128_DECRYPT_EN is defined.
module des128_half_rotator
  import des128_pkg::*;
(
  input  logic [HALF_W-1:0] din,
  input  rot_amt_t          amt,
`ifdef DES128_DECRYPT_EN
  input  logic              dir_right,
`endif
  output logic [HALF_W-1:0] dout
);

  localparam int HALF = HALF_W / 2;

  // A rotate by half the width is direction-independent.
  always_comb begin
    dout = din;
`ifdef DES128_DECRYPT_EN
    if (dir_right) begin
      case (amt)
        ROT_1:   dout = {din[0], din[HALF_W-1:1]};
        ROT_2:   dout = {din[1:0], din[HALF_W-1:2]};
        ROT_28:  dout = {din[HALF-1:0], din[HALF_W-1:HALF]};
        default: dout = din;
      endcase
    end else begin
      case (amt)
        ROT_1:   dout = {din[HALF_W-2:0], din[HALF_W-1]};
        ROT_2:   dout = {din[HALF_W-3:0], din[HALF_W-1:HALF_W-2]};
        ROT_28:  dout = {din[HALF-1:0], din[HALF_W-1:HALF]};
        default: dout = din;
      endcase
    end
`else
    case (amt)
      ROT_1:   dout = {din[HALF_W-2:0], din[HALF_W-1]};
      ROT_2:   dout = {din[HALF_W-3:0], din[HALF_W-1:HALF_W-2]};
      ROT_28:  dout = {din[HALF-1:0], din[HALF_W-1:HALF]};
      default: dout = din;
    endcase
`endif
  end

endmodule

// File: rtl/des128_key_scheduler.sv
// Walks C/D through the 16-round DES key schedule, one round state per handshake.
// DES128_DECRYPT_EN enables the reverse (decrypt) ordering selected by mode_dec.
module des128_key_scheduler
  import des128_pkg::*;
(
  input logic                   Clk,
  input logic                   Reset,
  input logic                   flush,
  des128_key_scheduler_if.slave bus
);

  localparam logic [RND_W-1:0] LAST_ROUND = RND_W'(ROUNDS - 1);

  state_t            state, state_next;
  logic [HALF_W-1:0] c_q, d_q;
  logic [HALF_W-1:0] c_src, d_src;
  logic [HALF_W-1:0] c_rot, d_rot;
  logic [RND_W-1:0]  round_q;
  logic              mode_q;
  logic              load;
  logic              accept;
  logic              advance;
  logic              emitting;
  rot_amt_t          rot_amt;

  assign emitting      = (state == EMIT);
  assign bus.key_ready = (state == IDLE) & ~flush & ~Reset;
  assign accept        = bus.key_valid & bus.key_ready;
  assign advance       = emitting & bus.rk_ready & ~flush;

  assign bus.rk_valid  = emitting;
  assign bus.rk_C      = c_q;
  assign bus.rk_D      = d_q;
  assign bus.rk_round  = round_q;
  assign bus.rk_last   = emitting & (round_q == LAST_ROUND);

`ifdef DES128_DECRYPT_EN
  logic rot_right;

  // Direction is latched with the key so mid-schedule mode_dec changes are ignored.
  always_ff @(posedge Clk) begin
    if (Reset)       mode_q <= 1'b0;
    else if (accept) mode_q <= bus.mode_dec;
  end
`else
  assign mode_q = 1'b0;
`endif

  // Decrypt starts from C16/D16 (a 28-bit rotate) and then walks the schedule backwards.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    c_src      = bus.C0_in;
    d_src      = bus.D0_in;
    rot_amt    = SHIFT_SCHED[0];
`ifdef DES128_DECRYPT_EN
    rot_right  = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (accept) begin
          state_next = EMIT;
          load       = 1'b1;
`ifdef DES128_DECRYPT_EN
          if (bus.mode_dec) rot_amt = ROT_28;
`endif
        end
      end
      EMIT: begin
        c_src   = c_q;
        d_src   = d_q;
        rot_amt = SHIFT_SCHED[round_q + RND_W'(1)];
`ifdef DES128_DECRYPT_EN
        if (mode_q) begin
          rot_amt   = SHIFT_SCHED[LAST_ROUND - round_q];
          rot_right = 1'b1;
        end
`endif
        if (advance) begin
          if (round_q == LAST_ROUND) state_next = IDLE;
          else                       load       = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
    if (flush) begin
      state_next = IDLE;
      load       = 1'b0;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state   <= IDLE;
      c_q     <= '0;
      d_q     <= '0;
      round_q <= '0;
    end else begin
      state <= state_next;
      if (flush) begin
        round_q <= '0;
      end else if (load) begin
        c_q     <= c_rot;
        d_q     <= d_rot;
        round_q <= (state == IDLE) ? '0 : round_q + RND_W'(1);
      end else if (advance) begin
        round_q <= '0;
      end
    end
  end

  des128_half_rotator u_rot_c (
    .din       (c_src),
    .amt       (rot_amt),
`ifdef DES128_DECRYPT_EN
    .dir_right (rot_right),
`endif
    .dout      (c_rot)
  );

  des128_half_rotator u_rot_d (
    .din       (d_src),
    .amt       (rot_amt),
`ifdef DES128_DECRYPT_EN
    .dir_right (rot_right),
`endif
    .dout      (d_rot)
  );

endmodule

// File: tb/tb_des128_key_scheduler.sv
// Self-checking bench for des128_key_scheduler: cumulative-shift reference model
// checked every cycle, plus hand-computed literal expectations per scenario.
module tb_des128_key_scheduler;
  import des128_pkg::*;

`ifdef DES128_DECRYPT_EN
  localparam bit DEC_EN = 1'b1;
`else
  localparam bit DEC_EN = 1'b0;
`endif

  logic Clk   = 1'b0;
  logic Reset = 1'b1;
  logic flush = 1'b0;

  int errors = 0;
  int checks = 0;
  bit compare_en = 1'b0;

  des128_key_scheduler_if bus ();

  des128_key_scheduler dut (
    .Clk   (Clk),
    .Reset (Reset),
    .flush (flush),
    .bus   (bus.slave)
  );

  always #5 Clk = ~Clk;

  // Reference: round r holds C0 rotated left by the running total of shifts.
  int sched [1:16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  function automatic logic [55:0] rotl56(input logic [55:0] x, input int n);
    int k;
    k = n % 56;
    if (k == 0) return x;
    return (x << k) | (x >> (56 - k));
  endfunction

  function automatic int cumShift(input int k);
    int s;
    s = 0;
    for (int i = 1; i <= k; i++) s += sched[i];
    return s;
  endfunction

  function automatic logic [55:0] modelHalf(input logic [55:0] h0, input int r, input bit dec);
    if (dec) return rotl56(h0, cumShift(16 - r));
    return rotl56(h0, cumShift(r + 1));
  endfunction

  bit          m_valid  = 1'b0;
  int          m_round  = 0;
  bit          m_dec    = 1'b0;
  logic [55:0] m_c0     = '0;
  logic [55:0] m_d0     = '0;
  logic [55:0] m_hold_c = '0;
  logic [55:0] m_hold_d = '0;

  always @(posedge Clk) begin
    if (Reset) begin
      m_valid  <= 1'b0;
      m_round  <= 0;
      m_hold_c <= '0;
      m_hold_d <= '0;
    end else begin
      if (m_valid) begin
        m_hold_c <= modelHalf(m_c0, m_round, m_dec);
        m_hold_d <= modelHalf(m_d0, m_round, m_dec);
      end
      if (flush) begin
        m_valid <= 1'b0;
        m_round <= 0;
      end else if (!m_valid && bus.key_valid) begin
        m_valid <= 1'b1;
        m_round <= 0;
        m_c0    <= bus.C0_in;
        m_d0    <= bus.D0_in;
        m_dec   <= DEC_EN & bus.mode_dec;
      end else if (m_valid && bus.rk_ready) begin
        if (m_round == 15) m_valid <= 1'b0;
        else               m_round <= m_round + 1;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  logic [55:0] exp_c, exp_d;

  always @(negedge Clk) begin
    if (compare_en) begin
      exp_c = m_valid ? modelHalf(m_c0, m_round, m_dec) : m_hold_c;
      exp_d = m_valid ? modelHalf(m_d0, m_round, m_dec) : m_hold_d;
      checkOutput("cyc_rk_valid", 64'(bus.rk_valid), 64'(m_valid));
      checkOutput("cyc_rk_last", 64'(bus.rk_last), 64'(m_valid && m_round == 15));
      checkOutput("cyc_key_ready", 64'(bus.key_ready), 64'(!m_valid && !flush && !Reset));
      checkOutput("cyc_rk_C", 64'(bus.rk_C), 64'(exp_c));
      checkOutput("cyc_rk_D", 64'(bus.rk_D), 64'(exp_d));
      if (m_valid) checkOutput("cyc_rk_round", 64'(bus.rk_round), 64'(m_round));
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic applyStimulus(input bit kv, input logic [55:0] c0, input logic [55:0] d0,
                               input bit dec, input bit rr, input bit fl);
    bus.key_valid = kv;
    bus.C0_in     = c0;
    bus.D0_in     = d0;
    bus.mode_dec  = dec;
    bus.rk_ready  = rr;
    flush         = fl;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 40 && bus.rk_valid === 1'b1; i++) tick();
    checkOutput(name, 64'(bus.rk_valid), 64'd0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  int cnt;

  initial begin
    applyStimulus(0, '0, '0, 0, 0, 0);
    tick();
    compare_en = 1'b1;
    tick();
    @(negedge Clk);
    checkOutput("rst_rk_valid", 64'(bus.rk_valid), 64'd0);
    checkOutput("rst_rk_C", 64'(bus.rk_C), 64'd0);
    checkOutput("rst_rk_D", 64'(bus.rk_D), 64'd0);
    checkOutput("rst_rk_round", 64'(bus.rk_round), 64'd0);
    checkOutput("rst_rk_last", 64'(bus.rk_last), 64'd0);
    checkOutput("rst_key_ready", 64'(bus.key_ready), 64'd0);
    tick();
    Reset = 1'b0;
    @(negedge Clk);
    checkOutput("post_rst_key_ready", 64'(bus.key_ready), 64'd1);

    $display("[TB] encrypt schedule");
    tick();
    applyStimulus(1, 56'h1, 56'h2, 0, 1, 0);
    tick();
    bus.key_valid = 1'b0;
    @(negedge Clk);
    checkOutput("enc_r0_C", 64'(bus.rk_C), 64'h2);
    checkOutput("enc_r0_D", 64'(bus.rk_D), 64'h4);
    checkOutput("enc_r0_round", 64'(bus.rk_round), 64'd0);
    tick();
    @(negedge Clk);
    checkOutput("enc_r1_C", 64'(bus.rk_C), 64'h4);
    tick();
    @(negedge Clk);
    checkOutput("enc_r2_C", 64'(bus.rk_C), 64'h10);
    repeat (13) tick();
    @(negedge Clk);
    checkOutput("enc_r15_C", 64'(bus.rk_C), 64'h0000_0010_0000_00);
    checkOutput("enc_r15_last", 64'(bus.rk_last), 64'd1);
    tick();
    @(negedge Clk);
    checkOutput("enc_done_valid", 64'(bus.rk_valid), 64'd0);
    checkOutput("enc_done_key_ready", 64'(bus.key_ready), 64'd1);
    checkOutput("enc_done_C_held", 64'(bus.rk_C), 64'h0000_0010_0000_00);

    $display("[TB] mode_dec key");
    tick();
    applyStimulus(1, 56'h1, 56'h2, 1, 1, 0);
    tick();
    bus.key_valid = 1'b0;
    @(negedge Clk);
    checkOutput("dec_r0_C", 64'(bus.rk_C), DEC_EN ? 64'(56'h1 << 28) : 64'h2);
    checkOutput("dec_r0_D", 64'(bus.rk_D), DEC_EN ? 64'(56'h1 << 29) : 64'h4);
    tick();
    @(negedge Clk);
    checkOutput("dec_r1_C", 64'(bus.rk_C), DEC_EN ? 64'(56'h1 << 27) : 64'h4);
    tick();
    @(negedge Clk);
    checkOutput("dec_r2_C", 64'(bus.rk_C), DEC_EN ? 64'(56'h1 << 25) : 64'h10);
    tick();
    @(negedge Clk);
    checkOutput("dec_r3_C", 64'(bus.rk_C), DEC_EN ? 64'(56'h1 << 23) : 64'h40);
    repeat (12) tick();
    @(negedge Clk);
    checkOutput("dec_r15_C", 64'(bus.rk_C), DEC_EN ? 64'h2 : 64'(56'h1 << 28));
    checkOutput("dec_r15_last", 64'(bus.rk_last), 64'd1);
    drain("dec_drain");

    $display("[TB] backpressure at round 3");
    tick();
    applyStimulus(1, 56'h1, 56'h3, 0, 1, 0);
    tick();
    bus.key_valid = 1'b0;
    repeat (3) tick();
    bus.rk_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge Clk);
      checkOutput("bp_valid", 64'(bus.rk_valid), 64'd1);
      checkOutput("bp_round", 64'(bus.rk_round), 64'd3);
      checkOutput("bp_C", 64'(bus.rk_C), 64'h40);
      checkOutput("bp_D", 64'(bus.rk_D), 64'hC0);
      tick();
    end
    bus.rk_ready = 1'b1;
    @(negedge Clk);
    checkOutput("bp_release_round", 64'(bus.rk_round), 64'd3);
    tick();
    @(negedge Clk);
    checkOutput("bp_resume_round", 64'(bus.rk_round), 64'd4);
    checkOutput("bp_resume_C", 64'(bus.rk_C), 64'h100);
    drain("bp_drain");

    $display("[TB] flush at round 7");
    tick();
    applyStimulus(1, 56'h1, 56'h2, 0, 1, 0);
    tick();
    bus.key_valid = 1'b0;
    repeat (7) tick();
    flush = 1'b1;
    @(negedge Clk);
    checkOutput("fl_round7", 64'(bus.rk_round), 64'd7);
    checkOutput("fl_key_ready_blocked", 64'(bus.key_ready), 64'd0);
    tick();
    applyStimulus(1, 56'h1, 56'h2, 0, 1, 0);
    @(negedge Clk);
    checkOutput("fl_valid", 64'(bus.rk_valid), 64'd0);
    checkOutput("fl_round", 64'(bus.rk_round), 64'd0);
    checkOutput("fl_key_ready", 64'(bus.key_ready), 64'd1);
    tick();
    bus.key_valid = 1'b0;
    @(negedge Clk);
    checkOutput("fl_restart_round", 64'(bus.rk_round), 64'd0);
    checkOutput("fl_restart_C", 64'(bus.rk_C), 64'h2);
    drain("fl_drain");

    $display("[TB] reset at round 10");
    tick();
    applyStimulus(1, 56'h5, 56'h9, 0, 1, 0);
    tick();
    bus.key_valid = 1'b0;
    repeat (10) tick();
    Reset = 1'b1;
    @(negedge Clk);
    checkOutput("rr_key_ready", 64'(bus.key_ready), 64'd0);
    tick();
    Reset = 1'b0;
    @(negedge Clk);
    checkOutput("rr_valid", 64'(bus.rk_valid), 64'd0);
    checkOutput("rr_C", 64'(bus.rk_C), 64'd0);
    checkOutput("rr_D", 64'(bus.rk_D), 64'd0);
    checkOutput("rr_round", 64'(bus.rk_round), 64'd0);
    checkOutput("rr_last", 64'(bus.rk_last), 64'd0);
    checkOutput("rr_key_ready_after", 64'(bus.key_ready), 64'd1);

    $display("[TB] back-to-back keys");
    tick();
    applyStimulus(1, 56'h1, 56'h2, 0, 1, 0);
    tick();
    applyStimulus(1, 56'h4, 56'h8, 0, 1, 0);
    cnt = 0;
    while (bus.rk_valid === 1'b1 && cnt < 40) begin
      cnt++;
      tick();
    end
    checkOutput("b2b_valid_cycles", 64'(cnt), 64'd16);
    @(negedge Clk);
    checkOutput("b2b_gap_valid", 64'(bus.rk_valid), 64'd0);
    checkOutput("b2b_gap_key_ready", 64'(bus.key_ready), 64'd1);
    tick();
    bus.key_valid = 1'b0;
    @(negedge Clk);
    checkOutput("b2b_second_valid", 64'(bus.rk_valid), 64'd1);
    checkOutput("b2b_second_round", 64'(bus.rk_round), 64'd0);
    checkOutput("b2b_second_C", 64'(bus.rk_C), 64'h8);
    drain("b2b_drain");

    repeat (2) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
